// File: rtl/hazard_pkg.sv
// Shared constants, stage record and source-hazard helper for hazard_stall_ctrl.
package hazard_pkg;

   localparam logic [1:0] TNEW_LOAD = 2'd2;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LINK = 2'd0;

   localparam logic       TUSE_D = 1'b0;
   localparam logic       TUSE_E = 1'b1;

   localparam logic [4:0] REG_RA = 5'd31;

   typedef struct packed {
      logic [4:0] a3;
      logic [1:0] tnew;
   } stage_rec_t;

   // A source stalls when its producer's result arrives later than it is needed.
   function automatic logic src_hazard(input logic [4:0] src, input logic used,
                                       input logic tuse, input stage_rec_t rec);
      return used && (src != 5'd0) && (src == rec.a3) && ({1'b0, tuse} < rec.tnew);
   endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Mult/div busy window: reloads on an MD start entering E, then counts down.
module md_busy_ctr
   import hazard_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start_mul,
   input  logic start_div,
   output logic md_busy
);

   localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          e_md_start_q, e_md_start_d;

   // The count is held while the start instruction sits in E, giving a 1 + N busy window.
   always_comb begin
      cnt_d        = cnt_q;
      e_md_start_d = start_mul | start_div;
      if (start_mul) begin
         cnt_d = CW'(MULT_CYC);
      end else if (start_div) begin
         cnt_d = CW'(DIV_CYC);
      end else if (!e_md_start_q && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         e_md_start_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         e_md_start_q <= e_md_start_d;
      end
   end

   assign md_busy = (cnt_q != '0) | e_md_start_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage stall controller: E/M result tracking plus MD busy interlock.
// Optional stall statistics counters are built when STALL_STAT_EN is defined.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  rs_d,
   input  logic [4:0]  rt_d,
   input  logic [4:0]  rd_d,
   input  logic        mov_c,
   input  logic        alr,
   input  logic        al,
   input  logic        cal_rd,
   input  logic        cal_rt,
   input  logic        load,
   input  logic        read_rs,
   input  logic        read_rt,
   input  logic        need_rs_d,
   input  logic        need_rt_d,
   input  logic        use_md,
   input  logic        md_mul_d,
   input  logic        md_div_d,
   input  logic        flush,
   output logic        stall,
   output logic        en_pc,
   output logic        en_d,
   output logic        clr_e,
   output logic        md_busy
`ifdef STALL_STAT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] md_stall_cnt
`endif
);

   stage_rec_t e_q, e_d, m_q, m_d;
   logic [4:0] a3_d;
   logic [1:0] tnew_d;
   logic       tuse_rs, tuse_rt;
   logic       data_stall, md_stall, transfer;

   always_comb begin
      a3_d = 5'd0;
      if (al) begin
         a3_d = REG_RA;
      end else if (alr | mov_c | cal_rd) begin
         a3_d = rd_d;
      end else if (cal_rt | load) begin
         a3_d = rt_d;
      end

      tnew_d = TNEW_LINK;
      if (load) begin
         tnew_d = TNEW_LOAD;
      end else if (cal_rd | cal_rt | mov_c) begin
         tnew_d = TNEW_ALU;
      end
   end

   assign tuse_rs = need_rs_d ? TUSE_D : TUSE_E;
   assign tuse_rt = need_rt_d ? TUSE_D : TUSE_E;

   assign data_stall = src_hazard(rs_d, need_rs_d | read_rs, tuse_rs, e_q)
                     | src_hazard(rs_d, need_rs_d | read_rs, tuse_rs, m_q)
                     | src_hazard(rt_d, need_rt_d | read_rt, tuse_rt, e_q)
                     | src_hazard(rt_d, need_rt_d | read_rt, tuse_rt, m_q);

   assign md_stall = use_md & md_busy;
   assign stall    = data_stall | md_stall;
   assign en_pc    = ~stall;
   assign en_d     = ~stall;
   // Flush must not leak a bubble request out while the block is held in reset.
   assign clr_e    = reset_n & (stall | flush);
   assign transfer = ~stall & ~flush;

   always_comb begin
      e_d = '{a3: a3_d, tnew: tnew_d};
      if (stall | flush) begin
         e_d = '0;
      end
      m_d = '{a3: e_q.a3, tnew: (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1};
      if (flush) begin
         m_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_q <= '0;
         m_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
      end
   end

   md_busy_ctr #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_busy_ctr (
      .clk       (clk),
      .reset_n   (reset_n),
      .start_mul (transfer & md_mul_d),
      .start_div (transfer & md_div_d & ~md_mul_d),
      .md_busy   (md_busy)
   );

`ifdef STALL_STAT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

   always_comb begin
      stall_cnt_d    = stall    ? stall_cnt_q + 32'd1    : stall_cnt_q;
      md_stall_cnt_d = md_stall ? md_stall_cnt_q + 32'd1 : md_stall_cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q    <= '0;
         md_stall_cnt_q <= '0;
      end else begin
         stall_cnt_q    <= stall_cnt_d;
         md_stall_cnt_q <= md_stall_cnt_d;
      end
   end

   assign stall_cnt    = stall_cnt_q;
   assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: instruction-level reference model feeding an expected queue.
module tb_hazard_stall_ctrl;

   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] rs_d = '0, rt_d = '0, rd_d = '0;
   logic       mov_c = 0, alr = 0, al = 0, cal_rd = 0, cal_rt = 0, load = 0;
   logic       read_rs = 0, read_rt = 0, need_rs_d = 0, need_rt_d = 0, use_md = 0;
   logic       md_mul_d = 0, md_div_d = 0, flush = 0;
   logic       stall, en_pc, en_d, clr_e, md_busy;
`ifdef STALL_STAT_EN
   logic [31:0] stall_cnt, md_stall_cnt;
`endif

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rs_d      (rs_d),
      .rt_d      (rt_d),
      .rd_d      (rd_d),
      .mov_c     (mov_c),
      .alr       (alr),
      .al        (al),
      .cal_rd    (cal_rd),
      .cal_rt    (cal_rt),
      .load      (load),
      .read_rs   (read_rs),
      .read_rt   (read_rt),
      .need_rs_d (need_rs_d),
      .need_rt_d (need_rt_d),
      .use_md    (use_md),
      .md_mul_d  (md_mul_d),
      .md_div_d  (md_div_d),
      .flush     (flush),
      .stall     (stall),
      .en_pc     (en_pc),
      .en_d      (en_d),
      .clr_e     (clr_e),
      .md_busy   (md_busy)
`ifdef STALL_STAT_EN
      ,
      .stall_cnt    (stall_cnt),
      .md_stall_cnt (md_stall_cnt)
`endif
   );

   typedef enum int {K_NOP, K_LW, K_BEQ, K_ADDU, K_JAL, K_JR, K_JALR,
                     K_ORI, K_MULT, K_DIV, K_MFLO, K_MFC0} kind_t;

   typedef struct {
      logic [4:0] rs, rt, rd;
      logic mov_c, alr, al, cal_rd, cal_rt, load;
      logic read_rs, read_rt, need_rs, need_rt, use_md, md_mul, md_div;
      int   dest;    // architectural destination, 0 when none
      int   lat;     // cycles after entering E before the result can be forwarded
      int   rs_use;  // -1: rs not read, 0: needed in D, 1: needed in E
      int   rt_use;
      int   md_cyc;  // MD unit occupancy it starts, 0 when none
   } instr_t;

   // Expected {stall, en_pc, en_d, clr_e, md_busy}
   logic [4:0] exp_q[$];
   logic [4:0] mon_exp, mon_got;
   int checks = 0;
   int errors = 0;

   // Reference model: producers tagged with the cycle they left D.
   int now = 0;
   int p_a3[$], p_lat[$], p_cyc[$];
   int md_last = -1;
   int exp_stall_cnt = 0, exp_md_stall_cnt = 0;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_got = {stall, en_pc, en_d, clr_e, md_busy};
         checks++;
         if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL outputs t=%0t stall/en_pc/en_d/clr_e/md_busy got %b expected %b",
                     $time, mon_got, mon_exp);
         end
      end
   end

   function automatic instr_t mk(input kind_t k, input int a, input int b, input int c);
      instr_t d;
      d = '{default: 0};
      d.rs = 5'($urandom_range(0, 31));
      d.rt = 5'($urandom_range(0, 31));
      d.rd = 5'($urandom_range(0, 31));
      d.rs_use = -1;
      d.rt_use = -1;
      case (k)
         K_LW:   begin d.load = 1; d.read_rs = 1; d.rt = 5'(a); d.rs = 5'(b);
                       d.dest = a; d.lat = 2; d.rs_use = 1; end
         K_BEQ:  begin d.need_rs = 1; d.need_rt = 1; d.rs = 5'(a); d.rt = 5'(b);
                       d.rs_use = 0; d.rt_use = 0; end
         K_ADDU: begin d.cal_rd = 1; d.read_rs = 1; d.read_rt = 1; d.rd = 5'(a);
                       d.rs = 5'(b); d.rt = 5'(c); d.dest = a; d.lat = 1;
                       d.rs_use = 1; d.rt_use = 1; end
         K_JAL:  begin d.al = 1; d.dest = 31; d.lat = 0; end
         K_JR:   begin d.need_rs = 1; d.rs = 5'(a); d.rs_use = 0; end
         K_JALR: begin d.alr = 1; d.need_rs = 1; d.rd = 5'(a); d.rs = 5'(b);
                       d.dest = a; d.lat = 0; d.rs_use = 0; end
         K_ORI:  begin d.cal_rt = 1; d.read_rs = 1; d.rt = 5'(a); d.rs = 5'(b);
                       d.dest = a; d.lat = 1; d.rs_use = 1; end
         K_MULT: begin d.md_mul = 1; d.use_md = 1; d.read_rs = 1; d.read_rt = 1;
                       d.rs = 5'(a); d.rt = 5'(b); d.rs_use = 1; d.rt_use = 1;
                       d.md_cyc = MULT_CYC; end
         K_DIV:  begin d.md_div = 1; d.use_md = 1; d.read_rs = 1; d.read_rt = 1;
                       d.rs = 5'(a); d.rt = 5'(b); d.rs_use = 1; d.rt_use = 1;
                       d.md_cyc = DIV_CYC; end
         K_MFLO: begin d.cal_rd = 1; d.use_md = 1; d.rd = 5'(a); d.dest = a; d.lat = 1; end
         K_MFC0: begin d.mov_c = 1; d.rd = 5'(a); d.dest = a; d.lat = 1; end
         default: ;
      endcase
      return d;
   endfunction

   task automatic drive(input instr_t d, input logic fl);
      rs_d = d.rs; rt_d = d.rt; rd_d = d.rd;
      mov_c = d.mov_c; alr = d.alr; al = d.al; cal_rd = d.cal_rd; cal_rt = d.cal_rt;
      load = d.load; read_rs = d.read_rs; read_rt = d.read_rt;
      need_rs_d = d.need_rs; need_rt_d = d.need_rt; use_md = d.use_md;
      md_mul_d = d.md_mul; md_div_d = d.md_div; flush = fl;
   endtask

   // Remaining latency of a producer: E is one cycle after leaving D, M two cycles after.
   function automatic logic hazard(input int src, input int use_t);
      for (int i = 0; i < p_a3.size(); i++) begin
         int age, rem;
         age = now - p_cyc[i];
         rem = 0;
         if (age == 1) rem = p_lat[i];
         else if (age == 2) rem = (p_lat[i] > 0) ? p_lat[i] - 1 : 0;
         if (use_t >= 0 && src != 0 && src == p_a3[i] && use_t < rem) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic step(input instr_t d, input logic fl, output logic st);
      logic busy, ds, ms;
      drive(d, fl);
      busy = (now <= md_last);
      ds   = hazard(int'(d.rs), d.rs_use) || hazard(int'(d.rt), d.rt_use);
      ms   = d.use_md && busy;
      st   = ds || ms;
      exp_q.push_back({st, !st, !st, st || fl, busy});
      if (st) exp_stall_cnt++;
      if (ms) exp_md_stall_cnt++;
      if (fl) begin
         p_a3.delete(); p_lat.delete(); p_cyc.delete();
      end else if (!st) begin
         p_a3.push_back(d.dest); p_lat.push_back(d.lat); p_cyc.push_back(now);
         if (d.md_cyc > 0) md_last = now + 1 + d.md_cyc;
      end
      while (p_cyc.size() > 0 && now - p_cyc[0] >= 2) begin
         void'(p_a3.pop_front()); void'(p_lat.pop_front()); void'(p_cyc.pop_front());
      end
      now++;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input instr_t d);
      logic st;
      int   n;
      n = 0;
      do begin
         step(d, 1'b0, st);
         n++;
      end while (st && n < 40);
      if (st) begin
         errors++;
         $display("FAIL issue_bound stall still %b after %0d cycles, required release", st, n);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(mk(K_MFLO, 3, 0, 0), 1'b1);
      exp_q.push_back(5'b01100);
      p_a3.delete(); p_lat.delete(); p_cyc.delete();
      md_last = -1;
      exp_stall_cnt = 0;
      exp_md_stall_cnt = 0;
      @(negedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic st;
      @(posedge clk);
      #1;
      do_reset();

      // Reset mid-divide, then mflo must go straight through.
      issue(mk(K_DIV, 1, 2, 0));
      issue(mk(K_NOP, 0, 0, 0));
      issue(mk(K_NOP, 0, 0, 0));
      issue(mk(K_NOP, 0, 0, 0));
      do_reset();
      issue(mk(K_MFLO, 3, 0, 0));

      // Load-use: beq needs $5 in D (2 stalls), addu needs it in E (1 stall).
      issue(mk(K_LW, 5, 1, 0));
      issue(mk(K_BEQ, 5, 0, 0));
      issue(mk(K_LW, 5, 1, 0));
      issue(mk(K_ADDU, 6, 5, 1));
      // Link results and $0 never stall.
      issue(mk(K_JAL, 0, 0, 0));
      issue(mk(K_JR, 31, 0, 0));
      issue(mk(K_ORI, 0, 1, 0));
      issue(mk(K_BEQ, 0, 0, 0));
      // MD interlock: 1 + MULT_CYC and 1 + DIV_CYC stall cycles.
      issue(mk(K_MULT, 1, 2, 0));
      issue(mk(K_MFLO, 3, 0, 0));
      issue(mk(K_DIV, 1, 2, 0));
      issue(mk(K_MFLO, 3, 0, 0));
      issue(mk(K_NOP, 0, 0, 0));

`ifdef STALL_STAT_EN
      checks++;
      if (stall_cnt !== 32'd20 || md_stall_cnt !== 32'd17) begin
         errors++;
         $display("FAIL stat_directed stall_cnt=%0d md_stall_cnt=%0d required 20 and 17",
                  stall_cnt, md_stall_cnt);
      end
`endif

      // Flush while a load-use stall is pending: bubble forced, E/M cleared.
      issue(mk(K_LW, 7, 1, 0));
      step(mk(K_BEQ, 7, 0, 0), 1'b1, st);
      issue(mk(K_BEQ, 7, 0, 0));
      // Flush does not cancel a multiply already in E.
      issue(mk(K_MULT, 1, 2, 0));
      step(mk(K_NOP, 0, 0, 0), 1'b1, st);
      issue(mk(K_MFLO, 4, 0, 0));

      for (int i = 0; i < 600; i++) begin
         kind_t k;
         int    a, b, c;
         k = kind_t'($urandom_range(0, 11));
         a = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 3);
         b = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(mk(k, a, b, c), ($urandom_range(0, 15) == 0), st);
         end
      end
      drive(mk(K_NOP, 0, 0, 0), 1'b0);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end
`ifdef STALL_STAT_EN
      checks++;
      if (stall_cnt !== 32'(exp_stall_cnt) || md_stall_cnt !== 32'(exp_md_stall_cnt)) begin
         errors++;
         $display("FAIL stat_random stall_cnt=%0d md_stall_cnt=%0d required %0d and %0d",
                  stall_cnt, md_stall_cnt, exp_stall_cnt, exp_md_stall_cnt);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Consumes the per-instruction class flags produced by the D-stage instruction classifier: movC, alr, al, cal_rd, cal_rt, load, readRs, readRt, needRsD, needRtD, useMD.
- Tracks the destination register and remaining result latency of the instructions in E and M, plus the mult/div unit busy window.
- Each cycle, decides whether the D-stage instruction must stall. Drives PC/D enables and the E bubble.

Parameters:
- MULT_CYC, 5, cycles the MD unit stays busy after mult/multu/madd/msub/maddu/msubu/mul enters E.
- DIV_CYC, 10, cycles the MD unit stays busy after div/divu enters E.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs_d  in  5  instr[25:21] of the D-stage instruction.
- rt_d  in  5  instr[20:16] of the D-stage instruction.
- rd_d  in  5  instr[15:11] of the D-stage instruction.
- mov_c, alr, al, cal_rd, cal_rt, load  in  1 each  class flags for D.
- read_rs, read_rt, need_rs_d, need_rt_d, use_md  in  1 each  class flags for D.
- md_mul_d  in  1  D instruction is a multiply-class MD start.
- md_div_d  in  1  D instruction is a divide-class MD start.
- flush  in  1  exception/eret flush; kills D→E transfer and clears E/M records.
- stall  out  1  D instruction must hold.
- en_pc  out  1  = !stall.
- en_d  out  1  = !stall.
- clr_e  out  1  = stall | flush; inserts a bubble into E.
- md_busy  out  1  MD unit busy.

Behaviour:
- Destination for D (a3_d):
  - al → 31.
  - alr, mov_c, cal_rd → rd_d.
  - cal_rt, load → rt_d.
  - Otherwise 0.
- Tnew at E entry:
  - load → 2.
  - cal_rd, cal_rt, mov_c → 1.
  - al, alr → 0.
  - Otherwise 0.
- Tuse for rs:
  - need_rs_d → 0.
  - Else read_rs → 1.
  - Else no use.
- Tuse for rt: same rule using need_rt_d / read_rt.
- Registers E_{a3,tnew} and M_{a3,tnew}.
- Each rising edge:
  - M ← {E_a3, max(E_tnew−1, 0)}.
  - E ← clr_e ? {0, 0} : {a3_d, Tnew_d}.
- Data stall: for each source s in {rs_d, rt_d} with a defined Tuse and s ≠ 0, stall if either holds:
  - s == E_a3 and Tuse < E_tnew.
  - s == M_a3 and Tuse < M_tnew.
- Register 0 never causes a stall.
- MD counter (cnt):
  - When a non-stalled, non-flushed D instruction with md_mul_d or md_div_d transfers to E, cnt loads MULT_CYC or DIV_CYC respectively.
  - Otherwise cnt decrements to 0 and saturates there.
  - md_busy = (cnt ≠ 0) | e_md_start, where e_md_start is a registered flag that is set for the one cycle the start instruction sits in E.
- MD stall: use_md && md_busy.
- stall = data stall | MD stall.
- Outputs are combinational from D inputs and registered state; zero added latency.
- Simultaneous events:
  - flush overrides stall: clr_e = 1.
  - An MD instruction already in E is not cancelled by flush; cnt keeps counting.
- Reset (asynchronous, mid-operation allowed):
  - E/M records are zeroed, cnt = 0, e_md_start = 0.
  - While reset_n is low: stall = 0, en_pc = en_d = 1, clr_e = 0, md_busy = 0.

Optional Feature:
- Macro STALL_STAT_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and md_stall_cnt[31:0].
  - stall_cnt increments every cycle stall = 1; md_stall_cnt increments every cycle the MD stall term = 1.
  - Both wrap modulo 2^32 and clear on reset.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - TNEW_LOAD = 2, TNEW_ALU = 1, TNEW_LINK = 0.
  - TUSE_D = 0, TUSE_E = 1.
  - REG_RA = 31.
  - A stage-record typedef {a3[4:0], tnew[1:0]}.
- One sub-module, md_busy_ctr, holds cnt, e_md_start and md_busy. It is parameterised by MULT_CYC and DIV_CYC.

Test Plan:
- lw $5 in E (E_a3 = 5, tnew 2), D = beq $5,$0 (need_rs_d) → stall = 1 for 2 cycles, clr_e = 1; released on cycle 3.
- lw $5 in E, D = addu $6,$5,$1 (read_rs, Tuse 1) → stall 1 cycle; next cycle M_tnew = 1, Tuse 1, so no stall.
- jal in E (a3 = 31, tnew 0), D = jr $31 → stall = 0. Also: ori $0,... in E, D = beq $0 → stall = 0.
- mult enters E, D = mflo the following cycles → stall for exactly 1 + 5 cycles, with md_busy high throughout. Same for div → 1 + 10 cycles.
- reset_n dropped mid-divide (cnt = 7) → md_busy = 0 and stall = 0 immediately; after release, mflo proceeds with no stall.
- STALL_STAT_EN: run the scenarios above → stall_cnt = 2 + 1 + 6 + 11 = 20 and md_stall_cnt = 17 at end.
